// File: rtl/fetch_unit.sv
// Instruction fetch front end. It issues sequential instruction-memory reads
// from a fetch PC and buffers the returned words in a 2-entry FIFO (head plus
// skid) that feeds the decoder. Redirects and reset flush both the FIFO and
// any read still in flight.
//
// Handshake: out_valid means out_instruction/out_pc hold a fetched word. A
// transfer happens on a rising edge where out_valid && out_ready. While
// out_valid=1 and out_ready=0, out_instruction/out_pc do not change.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 15
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instruction,
  output logic [31:0]        out_pc
);

  // PCs are always word aligned, including the one loaded on reset.
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0] fpc_q, fpc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;

  // Issue decision. A read is only issued if, after this cycle's pop, the
  // FIFO still has room for every response that can still arrive.
  always_comb begin
    pop       = (count_q != 2'd0) && out_ready;
    occupancy = {2'b00, inflight_q} + {1'b0, count_q} - {2'b00, pop};
    issue     = !rst && !redirect_valid && (occupancy < 3'd2);
    push      = inflight_q && !redirect_valid;
  end

  assign imem_en         = issue;
  assign imem_addr       = fpc_q[IMEM_AW+1:2];
  assign out_valid       = (count_q != 2'd0);
  assign out_instruction = head_instr_q;
  assign out_pc          = head_pc_q;

  // Next-state: fetch PC, in-flight tag and the head/skid FIFO.
  always_comb begin
    fpc_d         = fpc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    head_instr_d  = head_instr_q;
    head_pc_d     = head_pc_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;

    if (issue) begin
      fpc_d         = fpc_q + 32'd4;
      inflight_pc_d = fpc_q;
    end

    case ({push, pop})
      2'b11: begin
        // Count unchanged; the new word goes behind whatever remains.
        if (count_q == 2'd1) begin
          head_instr_d = imem_rdata;
          head_pc_d    = inflight_pc_q;
        end else begin
          head_instr_d = skid_instr_q;
          head_pc_d    = skid_pc_q;
          skid_instr_d = imem_rdata;
          skid_pc_d    = inflight_pc_q;
        end
      end
      2'b01: begin
        head_instr_d = skid_instr_q;
        head_pc_d    = skid_pc_q;
        count_d      = count_q - 2'd1;
      end
      2'b10: begin
        if (count_q == 2'd0) begin
          head_instr_d = imem_rdata;
          head_pc_d    = inflight_pc_q;
        end else begin
          skid_instr_d = imem_rdata;
          skid_pc_d    = inflight_pc_q;
        end
        count_d = count_q + 2'd1;
      end
      default: ;
    endcase

    // A redirect wins over everything: a handshake this cycle still belongs
    // to the decoder, but all buffered and in-flight words are dropped.
    if (redirect_valid) begin
      count_d = 2'd0;
      fpc_d   = redirect_pc & 32'hFFFF_FFFC;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q         <= RESET_PC_ALIGNED;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      count_q       <= 2'd0;
      head_instr_q  <= 32'd0;
      head_pc_q     <= 32'd0;
      skid_instr_q  <= 32'd0;
      skid_pc_q     <= 32'd0;
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      head_instr_q  <= head_instr_d;
      head_pc_q     <= head_pc_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Two instances: one with RESET_PC=0 that is
// driven through reset, stall, redirect and reset-pulse scenarios, and one
// with RESET_PC=FFFF_FFF8 that checks PC wrap-around. The instruction memory
// returns 32'hC0DE_0000 | word_address one cycle after each read strobe.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_ready = 1'b1;
  logic        b_redirect_valid = 1'b0;
  logic [31:0] b_redirect_pc = 32'd0;

  logic        a_imem_en, b_imem_en;
  logic [14:0] a_imem_addr, b_imem_addr;
  logic [31:0] a_imem_rdata = 32'd0, b_imem_rdata = 32'd0;
  logic        a_out_valid, b_out_valid;
  logic [31:0] a_out_instruction, b_out_instruction;
  logic [31:0] a_out_pc, b_out_pc;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_10 = 0;
  logic seen_14 = 1'b0;
  logic seen_300 = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(15)) u_a (
    .clk(clk), .rst(rst),
    .imem_en(a_imem_en), .imem_addr(a_imem_addr), .imem_rdata(a_imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_instruction(a_out_instruction), .out_pc(a_out_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(15)) u_b (
    .clk(clk), .rst(rst),
    .imem_en(b_imem_en), .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .out_valid(b_out_valid), .out_ready(1'b1),
    .out_instruction(b_out_instruction), .out_pc(b_out_pc)
  );

  // Instruction memories: one-cycle read latency.
  always @(posedge clk) begin
    if (a_imem_en) a_imem_rdata <= 32'hC0DE_0000 | {17'd0, a_imem_addr};
    if (b_imem_en) b_imem_rdata <= 32'hC0DE_0000 | {17'd0, b_imem_addr};
  end

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'hC0DE_0000 | ((pc >> 2) & 32'h0000_7FFF);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: move past the edge, apply inputs, let outputs settle, then log
  // what the decoder sees.
  task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    rst = r;
    redirect_valid = rv;
    redirect_pc = rpc;
    out_ready = rdy;
    #2;
    if (a_out_valid && out_ready && a_out_pc == 32'h10) cnt_10++;
    if (a_out_valid && a_out_pc == 32'h14) seen_14 = 1'b1;
    if (a_out_valid && a_out_pc == 32'h300) seen_300 = 1'b1;
  endtask

  initial begin
    // Reset state
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("rst_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_en", {31'd0, a_imem_en}, 32'd0);
    chk("rst_pc", a_out_pc, 32'd0);
    chk("rst_instr", a_out_instruction, 32'd0);
    chk("rst_b_valid", {31'd0, b_out_valid}, 32'd0);

    // Streaming after release, ready held high
    cyc(0, 0, 0, 1);
    chk("r0_en", {31'd0, a_imem_en}, 32'd1);
    chk("r0_addr", {17'd0, a_imem_addr}, 32'd0);
    chk("r0_valid", {31'd0, a_out_valid}, 32'd0);
    chk("r0_b_addr", {17'd0, b_imem_addr}, 32'h7FFE);
    cyc(0, 0, 0, 1);
    chk("r1_addr", {17'd0, a_imem_addr}, 32'd1);
    chk("r1_valid", {31'd0, a_out_valid}, 32'd0);
    cyc(0, 0, 0, 1);
    chk("r2_valid", {31'd0, a_out_valid}, 32'd1);
    chk("r2_pc", a_out_pc, 32'd0);
    chk("r2_instr", a_out_instruction, word_of(32'd0));
    chk("r2_addr", {17'd0, a_imem_addr}, 32'd2);
    chk("r2_b_pc", b_out_pc, 32'hFFFF_FFF8);
    chk("r2_b_instr", b_out_instruction, 32'hC0DE_7FFE);
    cyc(0, 0, 0, 1);
    chk("r3_pc", a_out_pc, 32'd4);
    chk("r3_b_pc", b_out_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    chk("r4_pc", a_out_pc, 32'd8);
    chk("r4_instr", a_out_instruction, word_of(32'd8));
    chk("r4_b_pc", b_out_pc, 32'h0000_0000);
    chk("r4_b_instr", b_out_instruction, 32'hC0DE_0000);

    // Stall: decoder not ready from release
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("q0_addr", {17'd0, a_imem_addr}, 32'd0);
    cyc(0, 0, 0, 0);
    chk("q1_en", {31'd0, a_imem_en}, 32'd1);
    chk("q1_addr", {17'd0, a_imem_addr}, 32'd1);
    cyc(0, 0, 0, 0);
    chk("q2_valid", {31'd0, a_out_valid}, 32'd1);
    chk("q2_en", {31'd0, a_imem_en}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0);
      chk("stall_en", {31'd0, a_imem_en}, 32'd0);
      chk("stall_pc", a_out_pc, 32'd0);
      chk("stall_valid", {31'd0, a_out_valid}, 32'd1);
    end
    cyc(0, 0, 0, 1);
    chk("q7_pc", a_out_pc, 32'd0);
    chk("q7_addr", {17'd0, a_imem_addr}, 32'd2);
    chk("q7_en", {31'd0, a_imem_en}, 32'd1);
    cyc(0, 0, 0, 1);
    chk("q8_pc", a_out_pc, 32'd4);
    cyc(0, 0, 0, 1);
    chk("q9_pc", a_out_pc, 32'd8);
    chk("q9_instr", a_out_instruction, word_of(32'd8));

    // Redirect to a misaligned PC with two buffered entries
    cyc(0, 0, 0, 0);
    chk("q10_pc", a_out_pc, 32'hC);
    chk("q10_en", {31'd0, a_imem_en}, 32'd0);
    cyc(0, 1, 32'h0000_0103, 0);
    chk("q11_en", {31'd0, a_imem_en}, 32'd0);
    cyc(0, 0, 0, 1);
    chk("q12_valid", {31'd0, a_out_valid}, 32'd0);
    chk("q12_en", {31'd0, a_imem_en}, 32'd1);
    chk("q12_addr", {17'd0, a_imem_addr}, 32'h40);
    cyc(0, 0, 0, 1);
    chk("q13_valid", {31'd0, a_out_valid}, 32'd0);
    cyc(0, 0, 0, 1);
    chk("q14_valid", {31'd0, a_out_valid}, 32'd1);
    chk("q14_pc", a_out_pc, 32'h100);
    chk("q14_instr", a_out_instruction, word_of(32'h100));
    cyc(0, 0, 0, 1);
    chk("q15_pc", a_out_pc, 32'h104);

    // Redirect coinciding with a handshake of pc 0x10
    cnt_10 = 0;
    seen_14 = 1'b0;
    cyc(0, 1, 32'h10, 1);
    cyc(0, 0, 0, 1);
    chk("q17_valid", {31'd0, a_out_valid}, 32'd0);
    chk("q17_addr", {17'd0, a_imem_addr}, 32'd4);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h200, 1);
    chk("q19_pc", a_out_pc, 32'h10);
    chk("q19_valid", {31'd0, a_out_valid}, 32'd1);
    chk("q19_en", {31'd0, a_imem_en}, 32'd0);
    cyc(0, 0, 0, 1);
    chk("q20_valid", {31'd0, a_out_valid}, 32'd0);
    chk("q20_addr", {17'd0, a_imem_addr}, 32'h80);
    cyc(0, 0, 0, 1);
    chk("q21_valid", {31'd0, a_out_valid}, 32'd0);
    cyc(0, 0, 0, 1);
    chk("q22_pc", a_out_pc, 32'h200);
    chk("q22_instr", a_out_instruction, word_of(32'h200));
    chk("accept_10_once", cnt_10, 32'd1);
    chk("never_14", {31'd0, seen_14}, 32'd0);

    // Back-to-back redirects: last one wins
    seen_300 = 1'b0;
    cyc(0, 1, 32'h300, 1);
    chk("q23_en", {31'd0, a_imem_en}, 32'd0);
    cyc(0, 1, 32'h404, 1);
    chk("q24_en", {31'd0, a_imem_en}, 32'd0);
    chk("q24_valid", {31'd0, a_out_valid}, 32'd0);
    cyc(0, 0, 0, 1);
    chk("q25_en", {31'd0, a_imem_en}, 32'd1);
    chk("q25_addr", {17'd0, a_imem_addr}, 32'h101);
    cyc(0, 0, 0, 1);
    chk("q26_valid", {31'd0, a_out_valid}, 32'd0);
    cyc(0, 0, 0, 1);
    chk("q27_pc", a_out_pc, 32'h404);
    chk("q27_instr", a_out_instruction, word_of(32'h404));
    chk("never_300", {31'd0, seen_300}, 32'd0);

    // Reset pulse mid-stream with reads in flight
    cyc(0, 0, 0, 1);
    chk("q28_pc", a_out_pc, 32'h408);
    cyc(1, 0, 0, 1);
    chk("q29_en", {31'd0, a_imem_en}, 32'd0);
    cyc(0, 0, 0, 1);
    chk("q30_valid", {31'd0, a_out_valid}, 32'd0);
    chk("q30_addr", {17'd0, a_imem_addr}, 32'd0);
    chk("q30_en", {31'd0, a_imem_en}, 32'd1);
    cyc(0, 0, 0, 1);
    chk("q31_valid", {31'd0, a_out_valid}, 32'd0);
    chk("q31_addr", {17'd0, a_imem_addr}, 32'd1);
    cyc(0, 0, 0, 1);
    chk("q32_valid", {31'd0, a_out_valid}, 32'd1);
    chk("q32_pc", a_out_pc, 32'd0);
    chk("q32_instr", a_out_instruction, word_of(32'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter IMEM_AW, default 15, instruction-memory word-address width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 imem_en  out  1  instruction-memory read strobe.
REQ-007 imem_addr  out  IMEM_AW  word address, equal to fetch PC[IMEM_AW+1:2].
REQ-008 imem_rdata  in  32  read data, valid exactly one cycle after an imem_en cycle.
REQ-009 redirect_valid  in  1  branch/jump taken; flush and restart fetch.
REQ-010 redirect_pc  in  32  new fetch PC when redirect_valid=1.
REQ-011 out_valid  out  1  out_instruction/out_pc hold a valid fetched instruction for the decoder.
REQ-012 out_ready  in  1  decoder accepts; transfer when out_valid && out_ready.
REQ-013 out_instruction  out  32  fetched instruction word.
REQ-014 out_pc  out  32  byte address of out_instruction.

Function
REQ-015 SHALL hold fetch PC register fpc; each issued read SHALL advance fpc by 4, mod 2^32 (wrap 32'hFFFF_FFFC -> 0).
REQ-016 SHALL force bits [1:0] of every PC (reset, increment, redirect) to 2'b00.
REQ-017 SHALL buffer data in a 2-entry FIFO (head drives out_*, plus one skid entry); out_valid = FIFO non-empty.
REQ-018 SHALL track inflight = 1 in the cycle after an issued read, 0 otherwise.
REQ-019 SHALL issue a read (imem_en=1, imem_addr=fpc) in a cycle iff rst=0, redirect_valid=0, and inflight + fifo_count - (out_valid && out_ready) < 2.
REQ-020 SHALL push imem_rdata, tagged with the PC of its request, into the FIFO in the cycle inflight=1, unless flushed.
REQ-021 SHALL pop the head on out_valid && out_ready; push and pop in the same cycle SHALL leave count unchanged and keep order.
REQ-022 SHALL never overflow the FIFO; REQ-019 guarantees space for every in-flight response.
REQ-023 out_instruction/out_pc SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 redirect_valid=1 SHALL, at that edge: empty the FIFO, drop any in-flight response (its data arriving the next cycle is discarded), and load fpc with redirect_pc.
REQ-025 During a redirect cycle no read SHALL issue; the first read from redirect_pc issues the following cycle, and its instruction appears with out_valid=1 two cycles after that issue.
REQ-026 redirect_valid SHALL take priority over out_ready; a handshake in the redirect cycle still completes (decoder owns that instruction), then the FIFO is flushed.
REQ-027 Back-to-back redirects SHALL each reload fpc; the last one wins, and no read issues while redirect_valid is held.
REQ-028 Steady state with out_ready held 1 SHALL deliver one instruction per cycle at consecutive PCs.
REQ-029 Latency: a read issued in cycle t produces out_valid at cycle t+2 if the FIFO was empty.

Reset
REQ-030 While rst=1: fpc=RESET_PC, FIFO empty, inflight=0, out_valid=0, imem_en=0; out_instruction/out_pc = 0.
REQ-031 First read SHALL issue in the first cycle with rst=0, at address RESET_PC.
REQ-032 rst asserted mid-operation SHALL discard FIFO contents and any in-flight response at that edge, with no further out_valid until new reads complete.

Verification
REQ-033 Reset release, out_ready=1, imem holds word i at address i -> imem_addr 0,1,2..., out_valid first high 2 cycles after release, out_pc 0,4,8 on consecutive cycles.
REQ-034 out_ready=0 for 5 cycles after the first out_valid -> exactly 2 reads outstanding/buffered, imem_en low thereafter, out_pc held at 0; ready=1 -> pcs 0,4,8 delivered without gaps or duplicates.
REQ-035 redirect_valid=1 with redirect_pc=32'h0000_0103 while FIFO holds 2 entries -> out_valid=0 next cycle, next imem_addr = 0x40, next out_pc = 0x100, stale data never presented.
REQ-036 redirect in the same cycle as a handshake of pc 0x10 -> 0x10 counted accepted once, pc 0x14 never presented.
REQ-037 RESET_PC=32'hFFFF_FFF8, out_ready=1 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rst pulsed one cycle mid-stream with data in flight -> out_valid=0 the following cycle, refetch starts at RESET_PC, in-flight data discarded.
